seq_detect_ctrl: RTL

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: configurable 1..4-bit serial pattern detector; SEQ_DETECT_CTRL_MATCH_CNT_EN adds a saturating match counter.
module seq_detect_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_pattern,
  input  logic [1:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clr_cnt,
  output logic             q,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt
);
  typedef enum logic [1:0] {IDLE, FLUSH, ARMED} state_t;
  state_t state_q, state_d;
  logic [3:0] pat_q, pat_d, hist_q, hist_d, hist_n, mask;
  logic [1:0] len_q, len_d;
  logic ovl_q, ovl_d, q_q, q_d, match;
  logic [2:0] fill_q, fill_d, fill_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      q_q     <= q_d;
    end
  end
  // Only the low L bits of history and pattern take part in the compare.
  assign mask   = {len_q == 2'd3, len_q >= 2'd2, len_q >= 2'd1, 1'b1};
  assign hist_n = {hist_q[2:0], x};
  assign fill_n = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    q_d     = 1'b0;
    match   = 1'b0;
    case (state_q)
      IDLE: if (cfg_valid) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        state_d = FLUSH;
      end
      FLUSH: begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = ARMED;
      end
      ARMED: begin
        if (stop) state_d = IDLE;
        else if (x_valid) begin
          match  = (fill_n > {1'b0, len_q}) && ((hist_n & mask) == (pat_q & mask));
          q_d    = match;
          hist_d = hist_n;
          fill_d = (match && !ovl_q) ? 3'd0 : fill_n;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign cfg_ready = (state_q == IDLE);
  assign busy      = !cfg_ready;
  assign q         = q_q;
`ifdef SEQ_DETECT_CTRL_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_cnt ? '0 : (match && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign match_cnt = cnt_q;
`else
  logic unused_cnt_in;
  assign unused_cnt_in = clr_cnt ^ match;
  assign match_cnt     = '0;
`endif
endmodule
